slc3_datapath_hs: RTL and testbench



---
 rtl/slc3_pkg.sv | 10 +
 rtl/slc3_datapath_hs_if.sv | 11 +
 rtl/slc3_mem_ctrl.sv | 64 ++++++
 rtl/slc3_datapath_hs.sv | 95 +++++++++
 tb/tb_slc3_datapath_hs.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/slc3_pkg.sv
// slc3_pkg: shared select encodings, memory FSM states and condition codes
package slc3_pkg;
    typedef enum logic [1:0] {PC_INC, PC_ADDR, PC_BUS, PC_HOLD} pcmux_t;
    typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2mux_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} aluk_t;
    typedef enum logic [1:0] {IDLE, RD, WR} mem_state_t;
    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;
endpackage

// File: rtl/slc3_datapath_hs_if.sv
// slc3_datapath_hs_if: req/ack memory port between the datapath and memory
interface slc3_datapath_hs_if #(parameter int W = 16);
    logic         mem_req;
    logic         mem_we;
    logic         mem_ack;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: memory access FSM with wait counter, timeout and held address/data
module slc3_mem_ctrl
    import slc3_pkg::*;
#(
    parameter int W       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd,
    input  logic               wr,
    input  logic [W-1:0]       addr,
    input  logic [W-1:0]       wdata,
    slc3_datapath_hs_if.master mem,
    output logic               busy,
    output logic               done,
    output logic               err_set,
    output logic               rd_done,
    output logic [W-1:0]       rd_data
);
    mem_state_t  state, state_nx;
    logic [15:0] cnt;
    logic        expire;

    // cnt is 0 in the first request cycle, so expiry lands on the TIMEOUT-th request cycle
    assign expire       = cnt == 16'(TIMEOUT - 1);
    assign busy         = state != IDLE;
    assign mem.mem_req  = busy;
    assign mem.mem_we   = state == WR;
    assign rd_done      = done && state == RD;
    assign rd_data      = mem.mem_ack ? mem.mem_rdata : '0;

    // state, wait counter and address/data captured at the start strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= busy ? cnt + 16'd1 : '0;
            if (!busy && (rd || wr)) begin
                mem.mem_addr <= addr;
                if (!rd) mem.mem_wdata <= wdata;
            end
        end
    end

    // next state; a simultaneous read/write start is a read flagged as an error, ack beats expiry
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        err_set  = 1'b0;
        if (!busy) begin
            state_nx = rd ? RD : wr ? WR : IDLE;
            err_set  = rd && wr;
        end else if (mem.mem_ack || expire) begin
            state_nx = IDLE;
            done     = 1'b1;
            err_set  = !mem.mem_ack;
        end
    end
endmodule

// File: rtl/slc3_datapath_hs.sv
// slc3_datapath_hs: parametrised single-bus SLC-3 datapath with handshaked memory port
module slc3_datapath_hs
    import slc3_pkg::*;
#(
    parameter int W       = 16,
    parameter int NREG    = 8,
    parameter int TIMEOUT = 255,
    parameter int LED_W   = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  logic               GatePC, GateMDR, GateALU, GateMARMUX,
    input  logic               SR2MUX, ADDR1MUX, DRMUX, SR1MUX,
    input  logic [1:0]         PCMUX, ADDR2MUX, ALUK,
    input  logic               MEM_RD, MEM_WR,
    output logic               MEM_DONE, MEM_BUSY, MEM_ERR, BUS_ERR, BEN,
    output logic [W-1:0]       MAR, MDR, PC, IR,
    output logic [LED_W-1:0]   LED,
    slc3_datapath_hs_if.master mem
);
    localparam int RA = $clog2(NREG);

    logic [W-1:0]  regs [NREG];
    logic [W-1:0]  bus, sr1, sr2, alu_b, alu, addr1, addr2, addr_sum, pc_nx, rd_data;
    logic [RA-1:0] dr, sr1_a, sr2_a;
    logic [2:0]    cc, cc_nx;
    logic          conflict, mem_err_set, rd_done;
    pcmux_t        pcm;
    addr2mux_t     a2m;
    aluk_t         alk;

    assign pcm      = pcmux_t'(PCMUX);
    assign a2m      = addr2mux_t'(ADDR2MUX);
    assign alk      = aluk_t'(ALUK);
    assign dr       = DRMUX ? RA'(IR[11:9]) : RA'(NREG - 1);
    assign sr1_a    = RA'(SR1MUX ? IR[8:6] : IR[11:9]);
    assign sr2_a    = RA'(IR[2:0]);
    assign sr1      = regs[sr1_a];
    assign sr2      = regs[sr2_a];
    assign alu_b    = SR2MUX ? {{(W-5){IR[4]}}, IR[4:0]} : sr2;
    assign addr1    = ADDR1MUX ? sr1 : PC;
    assign addr2    = a2m == A2_OFF11 ? {{(W-11){IR[10]}}, IR[10:0]} :
                      a2m == A2_OFF9  ? {{(W-9){IR[8]}}, IR[8:0]} :
                      a2m == A2_OFF6  ? {{(W-6){IR[5]}}, IR[5:0]} : '0;
    assign addr_sum = addr1 + addr2;
    assign alu      = alk == ALU_ADD ? sr1 + alu_b :
                      alk == ALU_AND ? sr1 & alu_b :
                      alk == ALU_NOT ? ~sr1 : sr1;
    assign conflict = $countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1;
    assign bus      = conflict ? '0 : ({W{GatePC}} & PC) | ({W{GateMDR}} & MDR) |
                      ({W{GateALU}} & alu) | ({W{GateMARMUX}} & addr_sum);
    assign cc_nx    = bus == '0 ? CC_Z : bus[W-1] ? CC_N : CC_P;
    assign pc_nx    = pcm == PC_INC  ? PC + W'(1) :
                      pcm == PC_ADDR ? addr_sum :
                      pcm == PC_BUS  ? bus : PC;

    slc3_mem_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) u_mem (
        .clk(Clk), .rst(Reset), .rd(MEM_RD), .wr(MEM_WR), .addr(MAR), .wdata(MDR),
        .mem(mem), .busy(MEM_BUSY), .done(MEM_DONE), .err_set(mem_err_set),
        .rd_done(rd_done), .rd_data(rd_data)
    );

    // architectural registers and sticky flags; MAR/MDR are frozen while an access is in flight
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            MAR     <= '0;
            MDR     <= '0;
            IR      <= '0;
            PC      <= '0;
            cc      <= '0;
            BEN     <= 1'b0;
            LED     <= '0;
            MEM_ERR <= 1'b0;
            BUS_ERR <= 1'b0;
        end else begin
            if (LD_MAR && !MEM_BUSY) MAR <= bus;
            if (rd_done) MDR <= rd_data;
            else if (LD_MDR && !MEM_BUSY) MDR <= bus;
            if (LD_IR) IR <= bus;
            if (LD_PC) PC <= pc_nx;
            if (LD_CC) cc <= cc_nx;
            if (LD_BEN) BEN <= |(IR[11:9] & cc);
            if (LD_LED) LED <= IR[LED_W-1:0];
            MEM_ERR <= MEM_ERR | mem_err_set;
            BUS_ERR <= BUS_ERR | conflict;
        end
    end

    // register file write port
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) for (int i = 0; i < NREG; i++) regs[i] <= '0;
        else if (LD_REG) regs[dr] <= bus;
    end
endmodule

// File: tb/tb_slc3_datapath_hs.sv
// tb_slc3_datapath_hs: directed checks on a W=16 and a W=32 datapath driven in lockstep
module tb_slc3_datapath_hs;
    logic Clk = 1'b0, Reset = 1'b1;
    logic LD_MAR = 0, LD_MDR = 0, LD_IR = 0, LD_BEN = 0, LD_CC = 0, LD_REG = 0, LD_PC = 0, LD_LED = 0;
    logic GatePC = 0, GateMDR = 0, GateALU = 0, GateMARMUX = 0;
    logic SR2MUX = 0, ADDR1MUX = 0, DRMUX = 0, SR1MUX = 0;
    logic [1:0] PCMUX = 0, ADDR2MUX = 0, ALUK = 0;
    logic MEM_RD = 0, MEM_WR = 0, mem_ack = 0;
    logic [31:0] rdata = 0;
    logic done_a, busy_a, merr_a, berr_a, ben_a, done_b, busy_b, merr_b, berr_b, ben_b;
    logic [15:0] mar_a, mdr_a, pc_a, ir_a;
    logic [31:0] mar_b, mdr_b, pc_b, ir_b;
    logic [9:0] led_a, led_b;
    int n = 0, errs = 0;
    int dcnt, req_a, req_b, dat_a, dat_b;

    always #5 Clk = ~Clk;

    slc3_datapath_hs_if #(.W(16)) ma ();
    slc3_datapath_hs_if #(.W(32)) mb ();
    assign ma.mem_ack   = mem_ack;
    assign ma.mem_rdata = rdata[15:0];
    assign mb.mem_ack   = mem_ack;
    assign mb.mem_rdata = rdata;

    slc3_datapath_hs #(.W(16), .NREG(8), .TIMEOUT(8), .LED_W(10)) u_a (
        .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC),
        .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
        .ALUK(ALUK), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_DONE(done_a), .MEM_BUSY(busy_a),
        .MEM_ERR(merr_a), .BUS_ERR(berr_a), .BEN(ben_a), .MAR(mar_a), .MDR(mdr_a), .PC(pc_a),
        .IR(ir_a), .LED(led_a), .mem(ma)
    );

    slc3_datapath_hs #(.W(32), .NREG(16), .TIMEOUT(4), .LED_W(10)) u_b (
        .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC),
        .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
        .ALUK(ALUK), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_DONE(done_b), .MEM_BUSY(busy_b),
        .MEM_ERR(merr_b), .BUS_ERR(berr_b), .BEN(ben_b), .MAR(mar_b), .MDR(mdr_b), .PC(pc_b),
        .IR(ir_b), .LED(led_b), .mem(mb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic clr;
        {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
        {GatePC, GateMDR, GateALU, GateMARMUX, SR2MUX, ADDR1MUX, DRMUX, SR1MUX} = '0;
        {PCMUX, ADDR2MUX, ALUK} = '0;
        {MEM_RD, MEM_WR} = '0;
    endtask

    task automatic mem_read(input logic [31:0] d);
        MEM_RD = 1; tick; MEM_RD = 0;
        mem_ack = 1; rdata = d; tick; mem_ack = 0;
    endtask

    task automatic load_ir(input logic [31:0] v);
        mem_read(v);
        GateMDR = 1; LD_IR = 1; tick; clr;
    endtask

    initial begin
        #12;
        check("rst_pc", pc_a, 0);
        check("rst_ir", ir_b, 0);
        check("rst_mdr", mdr_a, 0);
        check("rst_mar", mar_b, 0);
        check("rst_req", {ma.mem_req, mb.mem_req, done_a, busy_a}, 0);
        check("rst_flags", {merr_a, berr_a, ben_a, led_a}, 0);
        Reset = 0;
        tick;
        // MAR = 0x0042 through MDR
        mem_read(32'h42);
        GateMDR = 1; LD_MAR = 1; tick; clr;
        check("mar_load", mar_a, 16'h0042);
        // ack while idle is ignored
        mem_ack = 1; rdata = 32'h1234; #1;
        check("idle_ack_done", done_a, 0);
        tick; mem_ack = 0;
        check("idle_ack_mdr", mdr_a, 16'h0042);
        // read with three wait states, LD_MAR attempted while busy
        MEM_RD = 1; tick; clr;
        check("rd_req", {ma.mem_req, ma.mem_we}, 2'b10);
        check("rd_addr", ma.mem_addr, 16'h0042);
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            GatePC = 1; LD_MAR = 1;
            dcnt += int'(done_a);
            tick;
        end
        clr;
        mem_ack = 1; rdata = 32'hBEEF; #1;
        dcnt += int'(done_a);
        tick; mem_ack = 0;
        check("rd_done_cnt", dcnt, 1);
        check("rd_mdr_a", mdr_a, 16'hBEEF);
        check("rd_mdr_b", mdr_b, 32'h0000BEEF);
        check("rd_err", merr_a, 0);
        check("rd_req_drop", ma.mem_req, 0);
        check("mar_busy_hold", mar_a, 16'h0042);
        // timeout: B expires after 4 request cycles, A after 8
        MEM_RD = 1; tick; clr;
        req_a = 0; req_b = 0; dat_a = 0; dat_b = 0;
        for (int c = 1; c <= 10; c++) begin
            req_a += int'(ma.mem_req);
            req_b += int'(mb.mem_req);
            if (done_a) dat_a = c;
            if (done_b) dat_b = c;
            tick;
        end
        check("to_req_b", req_b, 4);
        check("to_done_b", dat_b, 4);
        check("to_req_a", req_a, 8);
        check("to_done_a", dat_a, 8);
        check("to_err_b", merr_b, 1);
        check("to_mdr_b", mdr_b, 0);
        check("to_mdr_a", mdr_a, 0);
        // ADD R15,R3,R4 with R3 = ~R0, R4 = 1
        load_ir(32'h0600);
        GateALU = 1; ALUK = 2; SR1MUX = 1; DRMUX = 1; LD_REG = 1; tick; clr;
        check("r3_not", u_b.regs[3], 32'hFFFFFFFF);
        load_ir(32'h0800);
        mem_read(32'h1);
        GateMDR = 1; DRMUX = 1; LD_REG = 1; tick; clr;
        check("r4_one", u_b.regs[4], 32'h1);
        load_ir(32'h10C4);
        u_b.regs[15] = 32'h5A5A5A5A;
        GateALU = 1; ALUK = 0; SR1MUX = 1; LD_REG = 1; LD_CC = 1; tick; clr;
        check("add_r15", u_b.regs[15], 32'h0);
        load_ir(32'h0400);
        LD_BEN = 1; tick; clr;
        check("cc_z", ben_b, 1);
        load_ir(32'h0A00);
        LD_BEN = 1; tick; clr;
        check("cc_not_np", ben_b, 0);
        // branch: CC=N, IR[11:9]=100, PC 0x3005 - 2
        mem_read(32'h3005);
        GateMDR = 1; PCMUX = 2; LD_PC = 1; tick; clr;
        check("pc_bus", pc_a, 16'h3005);
        mem_read(32'h8000);
        GateMDR = 1; LD_CC = 1; tick; clr;
        load_ir(32'h09FE);
        LD_BEN = 1; tick; clr;
        check("ben_a", ben_a, 1);
        check("ben_b", ben_b, 0);
        PCMUX = 1; ADDR2MUX = 2; LD_PC = 1; LD_LED = 1; tick; clr;
        check("br_pc_a", pc_a, 16'h3003);
        check("br_pc_b", pc_b, 32'h00003003);
        check("led", led_a, 10'h1FE);
        LD_PC = 1; tick; clr;
        check("pc_inc", pc_a, 16'h3004);
        // bus conflict
        check("berr_before", berr_a, 0);
        GatePC = 1; GateALU = 1; LD_MAR = 1; tick; clr;
        check("conflict_mar", mar_a, 0);
        check("conflict_berr", berr_a, 1);
        tick;
        check("berr_sticky", berr_a, 1);
        // reset in the second request cycle of a write
        MEM_WR = 1; tick; clr;
        check("wr_req", {ma.mem_req, ma.mem_we}, 2'b11);
        check("wr_data", ma.mem_wdata, 16'h09FE);
        tick;
        check("wr_req2", ma.mem_req, 1);
        Reset = 1; #1;
        check("rst_mid_req", {ma.mem_req, mb.mem_req, busy_a, done_a}, 0);
        check("rst_mid_flags", {berr_a, merr_b}, 0);
        tick; Reset = 0;
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            dcnt += int'(done_a) + int'(done_b);
            tick;
        end
        check("rst_no_done", dcnt, 0);
        check("rst_pc2", pc_a, 0);
        // simultaneous read+write starts a read and flags an error
        LD_PC = 1; tick; clr;
        MEM_RD = 1; MEM_WR = 1; tick; clr;
        check("dual_we", {ma.mem_req, ma.mem_we}, 2'b10);
        check("dual_err", merr_a, 1);
        GatePC = 1; LD_MAR = 1; tick; clr;
        check("dual_mar_hold", mar_a, 0);
        mem_ack = 1; rdata = 32'h5555; tick; mem_ack = 0;
        check("dual_mdr", mdr_a, 16'h5555);
        GatePC = 1; LD_MAR = 1; tick; clr;
        check("mar_after", mar_a, 16'h0001);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
